// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default framing constants shared by the UART TX and RX paths
package uart_pkg;

    localparam int DEFAULT_FRAME_WIDTH  = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/tx_baud_counter.sv
// tx_baud_counter: counts clocks within one bit period and flags the last clock of the bit
module tx_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_clr,
    input  logic cnt_en,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_tick = cnt_en && cnt_q == CW'(CLKS_PER_BIT - 1);

    always_comb cnt_d = (cnt_clr || bit_tick) ? '0 : cnt_en ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART serialiser with valid/ready input and done pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FRAME_WIDTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    localparam int BW = $clog2(FRAME_WIDTH);

    state_e                 state_q, state_d;
    logic [FRAME_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic                   tx_q, tx_d;
    logic                   bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    assign tx_ready = state_q == IDLE;
    assign busy     = state_q == START || state_q == DATA || state_q == PARITY || state_q == STOP;
    assign done     = state_q == DONE;
    assign tx       = tx_q;

    // Every state change restarts the bit period.
    tx_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .cnt_clr  (state_d != state_q),
        .cnt_en   (busy),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = '0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: if (tx_valid) begin
                state_d  = START;
                shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
                parity_d = ^tx_data;
`endif
            end
            START: if (bit_tick) state_d = DATA;
            DATA: begin
                bit_d = bit_q;
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BW'(FRAME_WIDTH - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_tick) state_d = STOP;
`endif
            STOP: if (bit_tick) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Line level follows the next state so tx switches on the same edge as the FSM.
        tx_d = state_d == START ? 1'b0 :
               state_d == DATA  ? shift_d[0] :
`ifdef UART_TX_PARITY_EN
               state_d == PARITY ? parity_q :
`endif
               1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
